// File: rtl/logical_unit_arbiter_pkg.sv
// Shared types and opcodes for the logical unit and its round-robin arbiter.
// The optional LU_ARB_OPCODE_CHECK_EN build only consumes the opcode values below.
package constants;

    localparam int WORD_SIZE   = 19;
    localparam int OPCODE_SIZE = 3;

    typedef struct packed {
        logic [OPCODE_SIZE-1:0] opcode;
        logic [WORD_SIZE-1:0]   op1;
        logic [WORD_SIZE-1:0]   op2;
    } lu_req_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_RESP
    } lu_arb_state_t;

endpackage

package opcodes;

    import constants::*;

    localparam logic [OPCODE_SIZE-1:0] OP_AND = 3'd0;
    localparam logic [OPCODE_SIZE-1:0] OP_OR  = 3'd1;
    localparam logic [OPCODE_SIZE-1:0] OP_XOR = 3'd2;
    localparam logic [OPCODE_SIZE-1:0] OP_NOT = 3'd3;

endpackage

package logical_unit_arbiter_pkg;

    // Round-robin successor: the index after idx, wrapping at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/logical_unit_arbiter_if.sv
// Request/response bundle between requesters, the arbiter and the response consumer.
interface logical_unit_arbiter_if
    import constants::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
);

    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0]                  req_ready;
    logic [NUM_REQ-1:0][OPCODE_SIZE-1:0] req_opcode;
    logic [NUM_REQ-1:0][WORD_SIZE-1:0]   req_op1;
    logic [NUM_REQ-1:0][WORD_SIZE-1:0]   req_op2;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [WORD_SIZE-1:0] rsp_data;
    logic                 rsp_err;

    modport master (
        output req_valid, req_opcode, req_op1, req_op2, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_opcode, req_op1, req_op2, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

endinterface

// File: rtl/logical_unit.sv
// Combinational bitwise logic unit: AND, OR, XOR and NOT on WORD_SIZE operands.
module logical_unit
    import constants::*;
    import opcodes::*;
(
    input  logic [OPCODE_SIZE-1:0] opcode,
    input  logic [WORD_SIZE-1:0]   op1,
    input  logic [WORD_SIZE-1:0]   op2,
    output logic [WORD_SIZE-1:0]   result
);

    // Undefined opcodes produce zero rather than an arbitrary operation.
    always_comb begin
        result = '0;
        case (opcode)
            OP_AND:  result = op1 & op2;
            OP_OR:   result = op1 | op2;
            OP_XOR:  result = op1 ^ op2;
            OP_NOT:  result = ~op1;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logical_unit_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after rr_ptr, with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(rr_ptr) + off) % NUM_REQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/logical_unit_arbiter.sv
// Round-robin sharing of one logical_unit with a registered, backpressured response.
// Optional build macro LU_ARB_OPCODE_CHECK_EN flags and zeroes illegal opcodes.
module logical_unit_arbiter
    import constants::*;
    import opcodes::*;
    import logical_unit_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    logical_unit_arbiter_if.slave bus
);

    lu_arb_state_t        state_q;
    logic [ID_W-1:0]      rr_ptr_q;
    logic                 rsp_valid_q;
    logic [ID_W-1:0]      rsp_id_q;
    logic [WORD_SIZE-1:0] rsp_data_q;

    logic                 can_accept;
    logic [NUM_REQ-1:0]   arb_req;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      grant_idx;
    logic                 accept;
    lu_req_t              sel;
    logic [WORD_SIZE-1:0] lu_result;
    logic [WORD_SIZE-1:0] next_data;

    // Holding reset low must never produce a req_ready pulse.
    assign can_accept = rst_n & ((state_q == ARB_IDLE) | (rsp_valid_q & bus.rsp_ready));
    assign arb_req    = can_accept ? bus.req_valid : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_rr (
        .req       (arb_req),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (accept)
    );

    assign bus.req_ready = grant;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel.opcode = bus.req_opcode[i];
                sel.op1    = bus.req_op1[i];
                sel.op2    = bus.req_op2[i];
            end
        end
    end

    logical_unit u_lu (
        .opcode (sel.opcode),
        .op1    (sel.op1),
        .op2    (sel.op2),
        .result (lu_result)
    );

`ifdef LU_ARB_OPCODE_CHECK_EN
    logic opcode_legal;
    logic rsp_err_q;

    assign opcode_legal = sel.opcode inside {OP_AND, OP_OR, OP_XOR, OP_NOT};
    assign next_data    = opcode_legal ? lu_result : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q <= 1'b0;
        end else if (accept) begin
            rsp_err_q <= ~opcode_legal;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign next_data   = lu_result;
    assign bus.rsp_err = 1'b0;
`endif

    // A grant in RESP implies the held response is being consumed, so it is replaced in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (accept) begin
                        state_q     <= ARB_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= grant_idx;
                        rsp_data_q  <= next_data;
                        rr_ptr_q    <= ID_W'(wrap_inc(32'(grant_idx), NUM_REQ));
                    end
                end
                ARB_RESP: begin
                    if (accept) begin
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= grant_idx;
                        rsp_data_q  <= next_data;
                        rr_ptr_q    <= ID_W'(wrap_inc(32'(grant_idx), NUM_REQ));
                    end else if (bus.rsp_ready) begin
                        state_q     <= ARB_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ARB_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_logical_unit_arbiter.sv
// Directed self-checking bench for logical_unit_arbiter with two requesters.
module tb_logical_unit_arbiter;

    import constants::*;
    import opcodes::*;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    localparam logic [WORD_SIZE-1:0] OPA     = 19'b1010101010101010101;
    localparam logic [WORD_SIZE-1:0] OPB     = 19'b1100110011001100110;
    localparam logic [WORD_SIZE-1:0] RES_AND = 19'b1000100010001000100;
    localparam logic [WORD_SIZE-1:0] RES_OR  = 19'b1110111011101110111;
    localparam logic [WORD_SIZE-1:0] RES_XOR = 19'b0110011001100110011;
    localparam logic [WORD_SIZE-1:0] RES_NOT = 19'b0101010101010101010;
    localparam logic [OPCODE_SIZE-1:0] OP_BAD = 3'd5;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logical_unit_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    logical_unit_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input int idx, input logic valid,
                                 input logic [OPCODE_SIZE-1:0] opc,
                                 input logic [WORD_SIZE-1:0] a,
                                 input logic [WORD_SIZE-1:0] b);
        bus.req_valid[idx]  = valid;
        bus.req_opcode[idx] = opc;
        bus.req_op1[idx]    = a;
        bus.req_op2[idx]    = b;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRsp(input string tag, input logic valid,
                            input logic [ID_W-1:0] id,
                            input logic [WORD_SIZE-1:0] data);
        checkOutput({tag, "_valid"}, 32'(bus.rsp_valid), 32'(valid));
        checkOutput({tag, "_id"},    32'(bus.rsp_id),    32'(id));
        checkOutput({tag, "_data"},  32'(bus.rsp_data),  32'(data));
    endtask

    initial begin
        logic [WORD_SIZE-1:0] exp_data;
        logic [ID_W-1:0]      exp_id;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.rsp_ready = 1'b0;
        applyStimulus(0, 1'b1, OP_AND, OPA, OPB);
        applyStimulus(1, 1'b1, OP_OR,  OPA, OPB);

        // Reset values, including no req_ready while valids are high.
        #12;
        checkRsp("reset", 1'b0, 1'b0, '0);
        checkOutput("reset_err",   32'(bus.rsp_err),   32'd0);
        checkOutput("reset_ready", 32'(bus.req_ready), 32'd0);
        applyStimulus(0, 1'b0, OP_AND, OPA, OPB);
        applyStimulus(1, 1'b0, OP_OR,  OPA, OPB);
        rst_n = 1'b1;
        tick();

        // Single requester AND.
        applyStimulus(0, 1'b1, OP_AND, OPA, OPB);
        bus.rsp_ready = 1'b1;
        #1 checkOutput("single_ready", 32'(bus.req_ready), 32'b01);
        tick();
        applyStimulus(0, 1'b0, OP_AND, OPA, OPB);
        checkRsp("single", 1'b1, 1'b0, RES_AND);
        checkOutput("single_err", 32'(bus.rsp_err), 32'd0);
        tick();
        checkOutput("single_drain", 32'(bus.rsp_valid), 32'd0);

        // NOT from requester 1 (pointer is 1 here), then idle cycles.
        applyStimulus(1, 1'b1, OP_NOT, OPA, 19'h7FFFF);
        #1 checkOutput("not_ready", 32'(bus.req_ready), 32'b10);
        tick();
        applyStimulus(1, 1'b0, OP_NOT, OPA, 19'h7FFFF);
        checkRsp("not", 1'b1, 1'b1, RES_NOT);
        tick();
        checkOutput("not_drain", 32'(bus.rsp_valid), 32'd0);
        tick();

        // Round robin with both requesters continuously valid.
        applyStimulus(0, 1'b1, OP_OR,  OPA, OPB);
        applyStimulus(1, 1'b1, OP_XOR, OPA, OPB);
        for (int k = 0; k < 4; k++) begin
            exp_id   = ID_W'(k % 2);
            exp_data = (k % 2 == 0) ? RES_OR : RES_XOR;
            #1 checkOutput($sformatf("rr%0d_ready", k), 32'(bus.req_ready),
                           (k % 2 == 0) ? 32'b01 : 32'b10);
            tick();
            checkRsp($sformatf("rr%0d", k), 1'b1, exp_id, exp_data);
        end

        // Backpressure: response holds, no grants.
        bus.rsp_ready = 1'b0;
        #1 checkOutput("bp_ready", 32'(bus.req_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkRsp($sformatf("bp%0d", k), 1'b1, 1'b1, RES_XOR);
            checkOutput($sformatf("bp%0d_ready", k), 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        #1 checkOutput("bp_release_ready", 32'(bus.req_ready), 32'b01);
        tick();
        checkRsp("bp_release", 1'b1, 1'b0, RES_OR);
        applyStimulus(0, 1'b0, OP_OR, OPA, OPB);
        #1 checkOutput("bp_next_ready", 32'(bus.req_ready), 32'b10);
        tick();
        checkRsp("bp_next", 1'b1, 1'b1, RES_XOR);
        applyStimulus(1, 1'b0, OP_XOR, OPA, OPB);
        tick();
        checkOutput("bp_drain", 32'(bus.rsp_valid), 32'd0);
        tick();

        // Pointer is 0; lone requester 1 must still win immediately.
        applyStimulus(1, 1'b1, OP_NOT, OPA, 19'h7FFFF);
        #1 checkOutput("alone_ready", 32'(bus.req_ready), 32'b10);
        tick();
        checkRsp("alone", 1'b1, 1'b1, RES_NOT);
        applyStimulus(1, 1'b0, OP_NOT, OPA, 19'h7FFFF);

        // Move pointer to 1, stall the response, then reset asynchronously.
        applyStimulus(0, 1'b1, OP_AND, OPA, OPB);
        #1 checkOutput("prerst_ready", 32'(bus.req_ready), 32'b01);
        tick();
        checkRsp("prerst", 1'b1, 1'b0, RES_AND);
        bus.rsp_ready = 1'b0;
        applyStimulus(1, 1'b1, OP_OR, OPA, OPB);
        #1 checkOutput("prerst_hold_ready", 32'(bus.req_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkRsp("midrst", 1'b0, 1'b0, '0);
        checkOutput("midrst_ready", 32'(bus.req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        #1 checkOutput("postrst_ready", 32'(bus.req_ready), 32'b01);
        tick();
        checkRsp("postrst", 1'b1, 1'b0, RES_AND);
        checkOutput("postrst_err", 32'(bus.rsp_err), 32'd0);

        // Illegal opcode; the default build passes the unit's zero result with no error.
        applyStimulus(1, 1'b0, OP_OR, OPA, OPB);
        applyStimulus(0, 1'b1, OP_BAD, OPA, OPB);
        #1 checkOutput("bad_ready", 32'(bus.req_ready), 32'b01);
        tick();
        checkOutput("bad_valid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("bad_id",    32'(bus.rsp_id),    32'd0);
        checkOutput("bad_data",  32'(bus.rsp_data),  32'd0);
`ifdef LU_ARB_OPCODE_CHECK_EN
        checkOutput("bad_err", 32'(bus.rsp_err), 32'd1);
`else
        checkOutput("bad_err", 32'(bus.rsp_err), 32'd0);
`endif
        applyStimulus(0, 1'b1, OP_AND, OPA, OPB);
        tick();
        checkRsp("good_after_bad", 1'b1, 1'b0, RES_AND);
        checkOutput("good_after_bad_err", 32'(bus.rsp_err), 32'd0);
        applyStimulus(0, 1'b0, OP_AND, OPA, OPB);
        tick();
        checkOutput("final_drain", 32'(bus.rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logical_unit_arbiter.md
# logical_unit_arbiter

Shares one `logical_unit` instance between `NUM_REQ` requesters, such as the decode/execute path and a debug/DMA port. It runs a round-robin arbiter, with one valid/ready request handshake per requester. The selected operands pass through the logical unit and the result is registered onto a single response port with backpressure. It sits between the requesting stages and the combinational logical unit, and gives a sustained throughput of one operation per cycle.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the response tag.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester accept, one-hot or zero.
- `req_opcode` in `NUM_REQ`×`OPCODE_SIZE`: per-requester opcode.
- `req_op1` in `NUM_REQ`×`WORD_SIZE`: per-requester operand 1.
- `req_op2` in `NUM_REQ`×`WORD_SIZE`: per-requester operand 2, ignored for NOT.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumer ready.
- `rsp_id` out `ID_W`: index of the requester that the response belongs to.
- `rsp_data` out `WORD_SIZE`: logical unit result.
- `rsp_err` out 1: illegal opcode flag. Only meaningful with `LU_ARB_OPCODE_CHECK_EN`.

## Operation
- **States:** `IDLE` (no response held) and `RESP` (response held).
- **Can-accept condition:** `can_accept = (state==IDLE) | (rsp_valid & rsp_ready)`.
- **Grant:** when `can_accept` is true and any `req_valid` is set, the arbiter grants the first valid requester at or after `rr_ptr`, searching in ascending index order with wrap.
  - `req_ready[g]=1` is driven combinationally in that cycle. All other `req_ready` bits are 0.
  - When `can_accept` is false, every `req_ready` bit is 0.
- **Accept:** the winner's opcode and operands are muxed into `logical_unit`. On the clock edge:
  - `rsp_data` ← LU output.
  - `rsp_id` ← g.
  - `rsp_valid` ← 1.
  - `rr_ptr` ← (g+1) mod `NUM_REQ`.
  - state ← `RESP`.
- **RESP transitions:**
  - `rsp_ready=0`: all response outputs hold stable. This is required.
  - `rsp_ready=1` with no new grant: `rsp_valid` ← 0 and state ← `IDLE`.
  - `rsp_ready=1` with a new grant: the response is replaced back-to-back and state stays `RESP`.
- **Pointer rule:** `rr_ptr` changes only on an accept. An idle cycle never moves it.
- **Request rules for requesters:**
  - Once `req_valid` is raised, it must stay high with stable payload until `req_ready`.
  - The arbiter does not latch unaccepted requests.
- **Width:** results are `WORD_SIZE` bits, bitwise only, with no carry.

## Timing
- Latency: a request accepted in cycle N has its response visible in cycle N+1.
- Throughput: one accept per cycle while `rsp_ready=1`.
- Reset values (asynchronous, while `rst_n=0`):
  - `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `rsp_err=0`.
  - `rr_ptr=0`, state=`IDLE`.
  - `req_ready` all 0.
- Reset mid-operation: the in-flight response is dropped and no `req_ready` pulse is generated. The first cycle after release behaves as `IDLE` with `rr_ptr=0`.
- A single valid requester is granted in every accepting cycle, regardless of `rr_ptr`.
- Simultaneous response consume and new grant in the same cycle is legal and requires no bubble.

## Configuration
- Macro: `LU_ARB_OPCODE_CHECK_EN`.
- **Defined:** when the accepted opcode is not one of AND, OR, XOR or NOT from the opcodes package:
  - the response has `rsp_err=1` and `rsp_data=0`;
  - the handshake, latency and `rsp_id` are unchanged.
- **Undefined:**
  - `rsp_err` is tied to 0;
  - `rsp_data` is whatever `logical_unit` outputs for that opcode;
  - no opcode decoding logic is present.

## Structure
- Use the existing `constants` package for `WORD_SIZE` and `OPCODE_SIZE`, and the `opcodes` package for AND, OR, XOR and NOT.
- Add to `constants`:
  - `typedef struct packed {opcode, op1, op2} lu_req_t`;
  - `typedef enum logic {ARB_IDLE, ARB_RESP} lu_arb_state_t`.
- Sub-module `rr_arbiter`, parameterised by `NUM_REQ`:
  - inputs: request vector, `rr_ptr`;
  - outputs: one-hot grant, grant index, `any`.
  - It is purely combinational.
- Instantiate `logical_unit` once. The pointer and state registers live in the top level.

## Test plan
1. **Single requester.** Requester 0 sends AND with 19'b1010101010101010101 and 19'b1100110011001100110.
   - Required: `req_ready[0]` in the same cycle.
   - Next cycle: `rsp_valid=1`, `rsp_id=0`, `rsp_data`=19'b1000100010001000100.
2. **Round robin.** Both requesters stay valid continuously with `rsp_ready=1` (requester 0 sends OR, requester 1 sends XOR, same operands).
   - Required grant sequence: 0,1,0,1, with one response per cycle.
   - `rsp_data` alternates 19'b1110111011101110111 and 19'b0110011001100110011.
3. **Backpressure.**
   - Hold `rsp_ready=0` for 3 cycles after a response. `rsp_valid`, `rsp_data` and `rsp_id` must stay stable, and all `req_ready` bits must be 0.
   - Raise `rsp_ready`. The next pending request must be granted in that same cycle.
4. **NOT and pointer hold.**
   - Requester 1 sends NOT 19'b1010101010101010101 with op2 = 19'h7FFFF. Required: result 19'b0101010101010101010.
   - After idle cycles, requester 1 is alone. It must be granted immediately.
5. **Reset mid-operation.** Assert `rst_n=0` while a response is in `RESP` with `rsp_ready=0`.
   - Required: outputs go to 0 immediately, without waiting for a clock edge.
   - After release, both requesters valid results in requester 0 being granted first.
6. **Opcode check, `LU_ARB_OPCODE_CHECK_EN` defined.** Send an opcode outside {AND, OR, XOR, NOT}.
   - Required: `rsp_err=1` and `rsp_data=0`.
   - A following AND produces `rsp_err=0`.
